// File: rtl/classifier_argmax_if.sv
// AXI-Stream bundle used for the score input and the result output of classifier_argmax.
interface classifier_argmax_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/classifier_argmax.sv
// Reduces a frame of signed per-class scores to {winning index, winning score},
// emitted as a 2-beat AXI-Stream frame; all outputs are registered.
module classifier_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  classifier_argmax_if.slave    s_axis,
  classifier_argmax_if.master   m_axis,
  output logic                  err_overflow,
  output logic [15:0]           frame_count
);

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    SEND_IDX   = 2'd1,
    SEND_SCORE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_WIDTH:0]            cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  best_q, best_d;
  logic [IDX_WIDTH-1:0]          idx_q, idx_d;
  logic                          s_tready_q, s_tready_d;
  logic                          m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]         m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]         m_tkeep_q, m_tkeep_d;
  logic                          m_tlast_q, m_tlast_d;
  logic                          err_overflow_q, err_overflow_d;
  logic [15:0]                   frame_count_q, frame_count_d;

  logic                          beat_acc;
  logic signed [DATA_WIDTH-1:0]  score;
  logic                          unused_keep;

  assign unused_keep = ^s_axis.tkeep;
  assign score       = $signed(s_axis.tdata);
  assign beat_acc    = s_axis.tvalid & s_tready_q & (state_q == ACCUM);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    best_d         = best_q;
    idx_d          = idx_q;
    s_tready_d     = s_tready_q;
    m_tvalid_d     = m_tvalid_q;
    m_tdata_d      = m_tdata_q;
    m_tkeep_d      = m_tkeep_q;
    m_tlast_d      = m_tlast_q;
    err_overflow_d = err_overflow_q;
    frame_count_d  = frame_count_q;

    case (state_q)
      ACCUM: begin
        s_tready_d = 1'b1;
        if (beat_acc) begin
          // cnt MSB set means the class index space is exhausted: drop the beat, flag it
          if (cnt_q == '0) begin
            best_d = score;
            idx_d  = '0;
          end else if (!cnt_q[IDX_WIDTH]) begin
            if (score > best_q) begin
              best_d = score;
              idx_d  = cnt_q[IDX_WIDTH-1:0];
            end
          end else begin
            err_overflow_d = 1'b1;
          end

          if (!cnt_q[IDX_WIDTH]) begin
            cnt_d = cnt_q + 1'b1;
          end

          if (s_axis.tlast) begin
            // Result beat0 is built from the post-compare index so the final beat counts
            cnt_d      = '0;
            state_d    = SEND_IDX;
            s_tready_d = 1'b0;
            m_tvalid_d = 1'b1;
            m_tdata_d  = DATA_WIDTH'(idx_d);
            m_tkeep_d  = '1;
            m_tlast_d  = 1'b0;
          end
        end
      end

      SEND_IDX: begin
        if (m_axis.tready) begin
          state_d   = SEND_SCORE;
          m_tdata_d = best_q;
          m_tlast_d = 1'b1;
        end
      end

      SEND_SCORE: begin
        if (m_axis.tready) begin
          state_d       = ACCUM;
          s_tready_d    = 1'b1;
          m_tvalid_d    = 1'b0;
          m_tdata_d     = '0;
          m_tkeep_d     = '0;
          m_tlast_d     = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ACCUM;
      cnt_q          <= '0;
      best_q         <= '0;
      idx_q          <= '0;
      s_tready_q     <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tdata_q      <= '0;
      m_tkeep_q      <= '0;
      m_tlast_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      best_q         <= best_d;
      idx_q          <= idx_d;
      s_tready_q     <= s_tready_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tdata_q      <= m_tdata_d;
      m_tkeep_q      <= m_tkeep_d;
      m_tlast_q      <= m_tlast_d;
      err_overflow_q <= err_overflow_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tlast  = m_tlast_q;
  assign err_overflow  = err_overflow_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_classifier_argmax.sv
// Scoreboard bench for classifier_argmax: directed plan cases plus random frames
// checked against an argmax reference model.
module tb_classifier_argmax;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int IW = 2;
  localparam int MAXC = 1 << IW;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err;
  logic [15:0] fc;

  classifier_argmax_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
  classifier_argmax_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

  classifier_argmax #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .err_overflow (err),
    .frame_count  (fc)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    exp_fc = 0;
  bit    exp_err = 0;
  int    ready_mode = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: first index holding the maximum among the first MAXC scores
  task automatic model(input int sc[$], output int idx, output int best, output bit ovf);
    idx  = 0;
    best = 0;
    for (int i = 0; i < sc.size() && i < MAXC; i++) begin
      if (i == 0 || sc[i] > best) begin
        best = sc[i];
        idx  = i;
      end
    end
    ovf = sc.size() > MAXC;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = 1'($urandom_range(0, 1));
      default: m_if.tready = 1'b0;
    endcase
  end

  // Monitor: pops expected beats on each output handshake and checks AXI-S hold
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_if.tvalid}, 32'd1);
        chk("hold_data", m_if.tdata, prev_data);
        chk("hold_last", {31'd0, m_if.tlast}, {31'd0, prev_last});
      end
      if (!m_if.tvalid) begin
        chk("idle_keep", {28'd0, m_if.tkeep}, 32'd0);
      end else if (m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", m_if.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_if.tdata, e.data);
          chk("beat_last", {31'd0, m_if.tlast}, {31'd0, e.last});
          chk("beat_keep", {28'd0, m_if.tkeep}, 32'hF);
          chk("frame_count", {16'd0, fc}, exp_fc[31:0]);
          if (e.last) exp_fc = (exp_fc + 1) & 16'hFFFF;
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  // Entered and left aligned at posedge+#1
  task automatic send_frame(input int sc[$], input bit gaps);
    int    idx, best;
    bit    ovf;
    beat_t b;
    model(sc, idx, best, ovf);
    b.data = DW'(idx);  b.last = 1'b0; exp_q.push_back(b);
    b.data = DW'(best); b.last = 1'b1; exp_q.push_back(b);
    if (ovf) exp_err = 1'b1;
    for (int i = 0; i < sc.size(); i++) begin
      int t = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = $urandom;
        s_if.tlast  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(sc[i]);
      s_if.tlast  = (i == sc.size() - 1);
      @(negedge clk);
      while (!s_if.tready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: got tready=0 expected 1 within 200 cycles");
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("latency_valid", {31'd0, m_if.tvalid}, 32'd1);
    chk("latency_tready", {31'd0, s_if.tready}, 32'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
    end
  endtask

  initial begin
    int sc[$];
    rst         = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd123;
    s_if.tkeep  = '1;
    s_if.tlast  = 1'b1;
    m_if.tready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_m_tdata", m_if.tdata, 32'd0);
    chk("rst_m_tkeep", {28'd0, m_if.tkeep}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_if.tlast}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fc", {16'd0, fc}, 32'd0);
    rst         = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_tready", {31'd0, s_if.tready}, 32'd1);
    chk("post_rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);

    sc = '{5, -3, 17, 2};
    send_frame(sc, 1'b0);
    wait_idle();
    chk("fc_after_first", {16'd0, fc}, 32'd1);

    sc = '{-8, -1, -1, -20};
    send_frame(sc, 1'b0);
    sc = '{-7};
    send_frame(sc, 1'b0);
    wait_idle();

    // Backpressure on beat0 with input offered during the stall
    ready_mode  = 2;
    m_if.tready = 1'b0;
    @(posedge clk); #1;
    sc = '{10, 30, 20};
    send_frame(sc, 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd999;
    s_if.tlast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_s_tready", {31'd0, s_if.tready}, 32'd0);
      chk("bp_idx_held", m_if.tdata, 32'd1);
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    ready_mode  = 0;
    wait_idle();
    chk("fc_after_bp", {16'd0, fc}, 32'd4);

    // Reset while beat0 is stalled
    ready_mode  = 2;
    m_if.tready = 1'b0;
    @(posedge clk); #1;
    sc = '{3, 1};
    send_frame(sc, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    exp_fc  = 0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    chk("midrst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("midrst_fc", {16'd0, fc}, 32'd0);
    rst        = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    sc = '{4, 9, 9};
    send_frame(sc, 1'b0);
    wait_idle();
    chk("midrst_err", {31'd0, err}, 32'd0);

    sc = '{1, 2, 3, 4, 99, 100};
    send_frame(sc, 1'b0);
    wait_idle();
    chk("ovf_set", {31'd0, err}, 32'd1);
    sc = '{6, 2};
    send_frame(sc, 1'b0);
    wait_idle();
    chk("ovf_sticky", {31'd0, err}, 32'd1);

    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, MAXC + 2);
      sc.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) sc.push_back(int'($urandom_range(0, 8)) - 4);
        else sc.push_back(int'($urandom));
      end
      send_frame(sc, 1'b1);
    end
    wait_idle();
    chk("final_fc", {16'd0, fc}, exp_fc[31:0]);
    chk("final_err", {31'd0, err}, {31'd0, exp_err});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end
endmodule
